// File: rtl/schedule_prog_mp_if.sv
// Bundles the host command channel and the page-command channel of
// schedule_prog_mp. The host/engine side (master) drives the i_* signals
// and observes the o_* signals; the scheduler (slave) does the reverse.
interface schedule_prog_mp_if;
    // host write-command channel
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [15:0] i_wcmd_id;
    logic [47:0] i_waddr;
    logic [23:0] i_wlen;
    logic [15:0] i_wcmd;
    logic [23:0] i_wdata_avail;

    // page-command channel towards the die engine
    logic        i_page_cmd_ready;
    logic        o_page_cmd_valid;
    logic [15:0] o_page_cmd;
    logic        o_page_cmd_last;
    logic [15:0] o_page_cmd_id;
    logic [47:0] o_page_addr;
    logic [31:0] o_page_cmd_param;
    logic        o_busy;

    modport master (
        output i_cmd_valid, i_wcmd_id, i_waddr, i_wlen, i_wcmd, i_wdata_avail,
        output i_page_cmd_ready,
        input  o_cmd_ready, o_page_cmd_valid, o_page_cmd, o_page_cmd_last,
        input  o_page_cmd_id, o_page_addr, o_page_cmd_param, o_busy
    );

    modport slave (
        input  i_cmd_valid, i_wcmd_id, i_waddr, i_wlen, i_wcmd, i_wdata_avail,
        input  i_page_cmd_ready,
        output o_cmd_ready, o_page_cmd_valid, o_page_cmd, o_page_cmd_last,
        output o_page_cmd_id, o_page_addr, o_page_cmd_param, o_busy
    );
endinterface

// File: rtl/schedule_prog_mp.sv
// Program scheduler: splits a host program request into page-sized chunks,
// issuing each as a multi-plane (0x1180) or final (0x1080) page command and
// walking the plane/page address; copyback (0x85) passes through as 0x1085.
// Each chunk waits until enough write data is buffered.
module schedule_prog_mp #(
    parameter int          PAGE_BYTES = 16384,
    parameter int          PLANE_NUM  = 2,
    parameter int          PLANE_LSB  = 16,
    parameter logic [11:0] COL_FIELD  = 12'h800
) (
    input  logic               clk,
    input  logic               rst,
    schedule_prog_mp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        COPR = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [7:0]  OP_PROGRAM  = 8'h80;
    localparam logic [7:0]  OP_COPYBACK = 8'h85;
    localparam logic [15:0] CMD_MULTI   = 16'h1180;
    localparam logic [15:0] CMD_FINAL   = 16'h1080;
    localparam logic [15:0] CMD_COPY    = 16'h1085;
    localparam logic [23:0] PAGE_LEN    = 24'(PAGE_BYTES);
    localparam logic [47:0] ADDR_STEP   = 48'd1 << PLANE_LSB;
    // a single-plane die still needs a 1-bit field to keep the slice legal
    localparam int          PLANE_W     = (PLANE_NUM > 1) ? $clog2(PLANE_NUM) : 1;
    localparam logic [15:0] PARAM_LO    = {COL_FIELD, 3'h6, 1'b1};

    state_t      state_q, state_d;
    logic [23:0] remaining_q, remaining_d;
    logic [47:0] addr_q, addr_d;
    logic [15:0] id_q, id_d;
    logic        valid_q, valid_d;
    logic [15:0] cmd_q, cmd_d;
    logic        last_q, last_d;
    logic [15:0] out_id_q, out_id_d;
    logic [47:0] page_addr_q, page_addr_d;
    logic [31:0] param_q, param_d;

    logic [23:0] chunk;
    logic        chunk_final;
    logic        plane_last;
    logic        accept;
    logic        unused_wcmd_hi;

    // the upper opcode byte carries nothing this block decodes
    assign unused_wcmd_hi = ^bus.i_wcmd[15:8];

    assign accept      = (state_q == IDLE) && bus.i_cmd_valid && bus.i_page_cmd_ready;
    assign chunk       = (remaining_q > PAGE_LEN) ? PAGE_LEN : remaining_q;
    assign chunk_final = (remaining_q == chunk);
    assign plane_last  = (PLANE_NUM == 1) ||
                         (addr_q[PLANE_LSB +: PLANE_W] == PLANE_W'(PLANE_NUM - 1));

    // Next-state and next-output logic for the request-splitting FSM.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        id_d        = id_q;
        valid_d     = valid_q;
        cmd_d       = cmd_q;
        last_d      = last_q;
        out_id_d    = out_id_q;
        page_addr_d = page_addr_q;
        param_d     = param_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d        = bus.i_wcmd_id;
                    addr_d      = bus.i_waddr;
                    remaining_d = bus.i_wlen;
                    if (bus.i_wcmd[7:0] == OP_PROGRAM && bus.i_wlen != 24'd0) begin
                        state_d = PROG;
                    end else if (bus.i_wcmd[7:0] == OP_COPYBACK) begin
                        state_d = COPR;
                    end
                end
            end

            PROG: begin
                if (bus.i_page_cmd_ready && (bus.i_wdata_avail >= chunk)) begin
                    valid_d     = 1'b1;
                    out_id_d    = id_q;
                    page_addr_d = addr_q;
                    param_d     = {chunk[15:0], PARAM_LO};
                    last_d      = chunk_final;
                    cmd_d       = (chunk_final || plane_last) ? CMD_FINAL : CMD_MULTI;
                    remaining_d = remaining_q - chunk;
                    // plane carry ripples into the page field; wrap at 2^48 is silent
                    addr_d      = addr_q + ADDR_STEP;
                    state_d     = WAIT;
                end
            end

            COPR: begin
                if (bus.i_page_cmd_ready) begin
                    valid_d     = 1'b1;
                    out_id_d    = id_q;
                    page_addr_d = addr_q;
                    param_d     = {16'h0000, PARAM_LO};
                    last_d      = 1'b1;
                    cmd_d       = CMD_COPY;
                    // copyback is a single command regardless of i_wlen
                    remaining_d = 24'd0;
                    state_d     = WAIT;
                end
            end

            WAIT: begin
                valid_d = 1'b0;
                // the engine signals acceptance by dropping ready for a cycle
                if (!(bus.i_page_cmd_ready || valid_q)) begin
                    state_d = (remaining_q != 24'd0) ? PROG : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            id_q        <= '0;
            valid_q     <= 1'b0;
            cmd_q       <= '0;
            last_q      <= 1'b0;
            out_id_q    <= '0;
            page_addr_q <= '0;
            param_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            valid_q     <= valid_d;
            cmd_q       <= cmd_d;
            last_q      <= last_d;
            out_id_q    <= out_id_d;
            page_addr_q <= page_addr_d;
            param_q     <= param_d;
        end
    end

    assign bus.o_cmd_ready      = (state_q == IDLE) && bus.i_page_cmd_ready;
    assign bus.o_busy           = (state_q != IDLE);
    assign bus.o_page_cmd_valid = valid_q;
    assign bus.o_page_cmd       = cmd_q;
    assign bus.o_page_cmd_last  = last_q;
    assign bus.o_page_cmd_id    = out_id_q;
    assign bus.o_page_addr      = page_addr_q;
    assign bus.o_page_cmd_param = param_q;

endmodule

// File: tb/tb_schedule_prog_mp.sv
// Self-checking bench for schedule_prog_mp: directed scenarios plus random
// requests, compared against a chunk-list model built from address/length
// arithmetic. A page-engine model drops ready for 2-4 cycles per command.
module tb_schedule_prog_mp;

    localparam int          PAGE_BYTES = 16384;
    localparam int          PLANE_NUM  = 2;
    localparam int          PLANE_LSB  = 16;
    localparam logic [11:0] COL_FIELD  = 12'h800;

    typedef struct {
        logic [15:0] cmd;
        logic [47:0] addr;
        logic        last;
        logic [15:0] id;
        logic [31:0] param;
        int          cyc;
        logic [23:0] avail;
    } pcmd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    schedule_prog_mp_if bus();

    schedule_prog_mp #(
        .PAGE_BYTES (PAGE_BYTES),
        .PLANE_NUM  (PLANE_NUM),
        .PLANE_LSB  (PLANE_LSB),
        .COL_FIELD  (COL_FIELD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    total = 0;
    int    bad   = 0;
    pcmd_t got[$];
    pcmd_t exp_q[$];
    int    pulse_errs;
    int    ready_errs;
    bit    timed_out;

    // ---------------- reference model ----------------
    function automatic logic [31:0] param_of(input longint len);
        return 32'(((len % 65536) << 16) | (longint'(COL_FIELD) << 4) | 13);
    endfunction

    task automatic expect_program(input logic [15:0] id, input logic [47:0] addr,
                                  input logic [23:0] len);
        logic [47:0] a;
        longint      rem, c, plane;
        bit          fin;
        pcmd_t       e;
        exp_q.delete();
        a   = addr;
        rem = longint'(len);
        while (rem > 0) begin
            c       = (rem > PAGE_BYTES) ? PAGE_BYTES : rem;
            fin     = (rem == c);
            plane   = longint'(a >> PLANE_LSB) % PLANE_NUM;
            e.cmd   = (fin || plane == PLANE_NUM - 1) ? 16'h1080 : 16'h1180;
            e.addr  = a;
            e.last  = fin;
            e.id    = id;
            e.param = param_of(c);
            e.cyc   = 0;
            e.avail = '0;
            exp_q.push_back(e);
            rem = rem - c;
            a   = a + (48'd1 << PLANE_LSB);
        end
    endtask

    task automatic expect_copyback(input logic [15:0] id, input logic [47:0] addr);
        pcmd_t e;
        exp_q.delete();
        e.cmd   = 16'h1085;
        e.addr  = addr;
        e.last  = 1'b1;
        e.id    = id;
        e.param = param_of(0);
        e.cyc   = 0;
        e.avail = '0;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus / engine model ----------------
    // Presents one host command and returns at the negedge after the accept edge.
    task automatic send_cmd(input logic [15:0] id, input logic [47:0] addr,
                            input logic [23:0] len, input logic [7:0] op,
                            input logic [23:0] avail);
        @(negedge clk);
        bus.i_cmd_valid      = 1'b1;
        bus.i_wcmd_id        = id;
        bus.i_waddr          = addr;
        bus.i_wlen           = len;
        bus.i_wcmd           = {8'h00, op};
        bus.i_wdata_avail    = avail;
        bus.i_page_cmd_ready = 1'b1;
        #1;
        total++;
        if (bus.o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready op=%h got=%b want=1", op, bus.o_cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    // Engine model: captures page commands and drops ready after each one.
    // Stops once n_stop commands are seen (early) or the block is idle again.
    task automatic collect(input int budget, input int n_stop, input bit early,
                           input bit rand_avail);
        bit          prev, done;
        int          drop;
        logic [23:0] last_avail;
        pcmd_t       pc;
        got.delete();
        pulse_errs = 0;
        ready_errs = 0;
        timed_out  = 1'b0;
        prev       = 1'b0;
        done       = 1'b0;
        drop       = 0;
        last_avail = bus.i_wdata_avail;
        for (int i = 0; i < budget && !done; i++) begin
            if (bus.o_page_cmd_valid === 1'b1) begin
                if (prev) pulse_errs++;
                pc.cmd   = bus.o_page_cmd;
                pc.addr  = bus.o_page_addr;
                pc.last  = bus.o_page_cmd_last;
                pc.id    = bus.o_page_cmd_id;
                pc.param = bus.o_page_cmd_param;
                pc.cyc   = i;
                pc.avail = last_avail;
                got.push_back(pc);
                bus.i_page_cmd_ready = 1'b0;
                drop = $urandom_range(2, 4);
            end else if (drop > 0) begin
                drop--;
                if (drop == 0) bus.i_page_cmd_ready = 1'b1;
            end
            if (bus.o_busy === 1'b1 && bus.o_cmd_ready !== 1'b0) ready_errs++;
            prev = bus.o_page_cmd_valid;
            if (early && got.size() >= n_stop) done = 1'b1;
            else if (!early && got.size() >= n_stop && bus.o_busy === 1'b0 && drop == 0) done = 1'b1;
            if (!done) begin
                if (rand_avail) bus.i_wdata_avail = 24'($urandom_range(0, 20000));
                last_avail = bus.i_wdata_avail;
                @(negedge clk);
            end
        end
        if (!done) timed_out = 1'b1;
        bus.i_page_cmd_ready = early ? bus.i_page_cmd_ready : 1'b1;
    endtask

    // Scoreboard: captured commands against the model's chunk list.
    task automatic score_chunks(input string name);
        int n;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s timeout got_cmds=%0d want_cmds=%0d", name, got.size(), exp_q.size());
        end
        total++;
        if (got.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s count got=%0d want=%0d", name, got.size(), exp_q.size());
        end
        total++;
        if (pulse_errs != 0 || ready_errs != 0) begin
            bad++;
            $display("FAIL %s protocol got pulse_errs=%0d ready_errs=%0d want 0/0",
                     name, pulse_errs, ready_errs);
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got[i].cmd !== exp_q[i].cmd) begin
                bad++;
                $display("FAIL %s[%0d] cmd got=%h want=%h", name, i, got[i].cmd, exp_q[i].cmd);
            end
            total++;
            if (got[i].addr !== exp_q[i].addr) begin
                bad++;
                $display("FAIL %s[%0d] addr got=%h want=%h", name, i, got[i].addr, exp_q[i].addr);
            end
            total++;
            if (got[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL %s[%0d] last got=%b want=%b", name, i, got[i].last, exp_q[i].last);
            end
            total++;
            if (got[i].id !== exp_q[i].id) begin
                bad++;
                $display("FAIL %s[%0d] id got=%h want=%h", name, i, got[i].id, exp_q[i].id);
            end
            total++;
            if (got[i].param !== exp_q[i].param) begin
                bad++;
                $display("FAIL %s[%0d] param got=%h want=%h", name, i, got[i].param, exp_q[i].param);
            end
            total++;
            if (got[i].avail < 24'(got[i].param[31:16])) begin
                bad++;
                $display("FAIL %s[%0d] data_gate got avail=%0d want>=%0d",
                         name, i, got[i].avail, got[i].param[31:16]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst                  = 1'b1;
        bus.i_cmd_valid      = 1'b0;
        bus.i_wcmd_id        = '0;
        bus.i_waddr          = '0;
        bus.i_wlen           = '0;
        bus.i_wcmd           = '0;
        bus.i_wdata_avail    = '0;
        bus.i_page_cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.o_page_cmd_valid, bus.o_page_cmd, bus.o_page_cmd_last, bus.o_page_cmd_id,
             bus.o_page_addr, bus.o_page_cmd_param, bus.o_busy, bus.o_cmd_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b cmd=%h busy=%b ready=%b want all 0",
                     bus.o_page_cmd_valid, bus.o_page_cmd, bus.o_busy, bus.o_cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.i_page_cmd_ready = 1'b1;
        #1;
        total++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_follow got ready=%b busy=%b want 1/0", bus.o_cmd_ready, bus.o_busy);
        end
        bus.i_page_cmd_ready = 1'b0;
        #1;
        total++;
        if (bus.o_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_drop got=%b want=0", bus.o_cmd_ready);
        end
        bus.i_page_cmd_ready = 1'b1;
    endtask

    task automatic test_single_chunk();
        send_cmd(16'h0011, 48'h0, 24'd4096, 8'h80, 24'd4096);
        expect_program(16'h0011, 48'h0, 24'd4096);
        collect(100, 1, 1'b0, 1'b0);
        score_chunks("single");
        total++;
        if (got.size() == 0 || got[0].cyc != 1) begin
            bad++;
            $display("FAIL single_latency got=%0d want=1", (got.size() == 0) ? -1 : got[0].cyc);
        end
    endtask

    task automatic test_multi_chunk();
        send_cmd(16'h0022, 48'h0, 24'd40000, 8'h80, 24'hFFFFFF);
        expect_program(16'h0022, 48'h0, 24'd40000);
        collect(200, 3, 1'b0, 1'b0);
        score_chunks("multi");
        total++;
        if (bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL multi_idle got busy=%b want=0", bus.o_busy);
        end
    endtask

    task automatic test_data_stall();
        int early_valid;
        early_valid = 0;
        send_cmd(16'h0033, 48'h0, 24'd16384, 8'h80, 24'd100);
        repeat (50) begin
            if (bus.o_page_cmd_valid !== 1'b0 || bus.o_busy !== 1'b1) early_valid++;
            @(negedge clk);
        end
        total++;
        if (early_valid != 0) begin
            bad++;
            $display("FAIL stall_hold got bad_cycles=%0d want=0", early_valid);
        end
        bus.i_wdata_avail = 24'd16384;
        expect_program(16'h0033, 48'h0, 24'd16384);
        collect(100, 1, 1'b0, 1'b0);
        score_chunks("stall");
        total++;
        if (got.size() == 0 || got[0].cyc > 2) begin
            bad++;
            $display("FAIL stall_release got=%0d want<=2", (got.size() == 0) ? -1 : got[0].cyc);
        end
    endtask

    task automatic test_copyback();
        send_cmd(16'h0055, 48'h30000, 24'd4096, 8'h85, 24'd0);
        expect_copyback(16'h0055, 48'h30000);
        collect(100, 1, 1'b0, 1'b0);
        score_chunks("copyback");
    endtask

    task automatic test_edge_opcodes();
        int stray;
        stray = 0;
        send_cmd(16'h0066, 48'h10000, 24'd0, 8'h80, 24'hFFFFFF);
        repeat (10) begin
            if (bus.o_page_cmd_valid !== 1'b0 || bus.o_busy !== 1'b0) stray++;
            @(negedge clk);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL zero_len got stray=%0d want=0", stray);
        end
        stray = 0;
        send_cmd(16'h0077, 48'h10000, 24'd4096, 8'h90, 24'hFFFFFF);
        repeat (10) begin
            if (bus.o_page_cmd_valid !== 1'b0 || bus.o_busy !== 1'b0) stray++;
            @(negedge clk);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL bad_opcode got stray=%0d want=0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        send_cmd(16'h0088, 48'h0, 24'd40000, 8'h80, 24'hFFFFFF);
        collect(200, 2, 1'b1, 1'b0);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL reset_mid_setup got cmds=%0d want=2", got.size());
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.o_page_cmd_valid, bus.o_page_cmd, bus.o_page_cmd_last, bus.o_page_cmd_id,
             bus.o_page_addr, bus.o_page_cmd_param, bus.o_busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got valid=%b cmd=%h addr=%h busy=%b want all 0",
                     bus.o_page_cmd_valid, bus.o_page_cmd, bus.o_page_addr, bus.o_busy);
        end
        rst = 1'b0;
        bus.i_page_cmd_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_page_cmd_valid !== 1'b0 || bus.o_busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_mid_no_chunk3 got stray=%0d want=0", stray);
        end
        send_cmd(16'h0099, 48'h40000, 24'd20000, 8'h80, 24'hFFFFFF);
        expect_program(16'h0099, 48'h40000, 24'd20000);
        collect(200, 2, 1'b0, 1'b0);
        score_chunks("after_reset");
    endtask

    task automatic test_random();
        logic [15:0] id;
        logic [47:0] addr;
        logic [23:0] len;
        bit          copy;
        for (int r = 0; r < 10; r++) begin
            id   = 16'($urandom);
            addr = {16'($urandom), 32'($urandom)};
            if (r == 0) addr = 48'hFFFF_FFFF_0000 | 48'h0; // exercises the 2^48 wrap
            len  = 24'($urandom_range(1, 50000));
            copy = ($urandom_range(0, 3) == 0);
            if (copy) begin
                send_cmd(id, addr, len, 8'h85, 24'($urandom_range(0, 20000)));
                expect_copyback(id, addr);
                collect(600, 1, 1'b0, 1'b1);
                score_chunks("rand_copy");
            end else begin
                send_cmd(id, addr, len, 8'h80, 24'($urandom_range(0, 20000)));
                expect_program(id, addr, len);
                collect(1500, exp_q.size(), 1'b0, 1'b1);
                score_chunks("rand_prog");
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_data_stall();
        test_copyback();
        test_edge_opcodes();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
